// File: rtl/miso_oversample_deserializer.sv
// Oversampled MISO deserializer: per-frame phase lag, one WORD_BITS word per channel.
// Optional MISO_MAJORITY_VOTE_EN: each bit is the 2-of-3 vote of samples d, d+1, d+2.
module miso_oversample_deserializer #(
  parameter int OSR       = 4,
  parameter int WORD_BITS = 32,
  parameter int DELAY_MAX = 9,
  parameter int NUM_CH    = 2,
  parameter int PW        = 4
) (
  input  logic                        dataclk,
  input  logic                        reset_n,
  input  logic                        sample_en,
  input  logic [NUM_CH-1:0]           miso_in,
  input  logic                        frame_start,
  input  logic [PW-1:0]               phase_select,
  output logic [NUM_CH*WORD_BITS-1:0] word_out,
  output logic                        word_valid,
  output logic                        frame_abort,
  output logic                        busy
);

`ifdef MISO_MAJORITY_VOTE_EN
  localparam int VOTE_SPAN = 2;
`else
  localparam int VOTE_SPAN = 0;
`endif
  localparam int N_LEN = WORD_BITS * OSR + DELAY_MAX + VOTE_SPAN;
  localparam int N_MV  = WORD_BITS * OSR + DELAY_MAX + 2;
  localparam int CW    = $clog2(N_MV + 1);
  localparam int LW    = PW + 1;
  localparam int SW    = $clog2(OSR);
  localparam int BW    = $clog2(WORD_BITS + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]        lag_q, lag_d;
  logic [SW-1:0]        sub_q, sub_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [WORD_BITS-1:0] sh_q [NUM_CH];
  logic [WORD_BITS-1:0] sh_d [NUM_CH];
  logic [NUM_CH*WORD_BITS-1:0] word_d;
  logic                 valid_d, abort_d, take;
  logic [PW-1:0]        ph_clamp;
  logic                 bit_val;
`ifdef MISO_MAJORITY_VOTE_EN
  logic [1:0]           hist_q [NUM_CH];
  logic [1:0]           hist_d [NUM_CH];
`endif

  assign busy = (state_q == COLLECT);

  // Instead of storing the whole frame, a lag counter skips the first ph(+vote span)
  // samples and an OSR sub-counter picks every OSR-th sample after that.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lag_d    = lag_q;
    sub_d    = sub_q;
    bits_d   = bits_q;
    sh_d     = sh_q;
    word_d   = word_out;
    valid_d  = 1'b0;
    abort_d  = 1'b0;
    take     = 1'b0;
    bit_val  = 1'b0;
    ph_clamp = (phase_select > PW'(DELAY_MAX)) ? PW'(DELAY_MAX) : phase_select;
`ifdef MISO_MAJORITY_VOTE_EN
    hist_d   = hist_q;
`endif

    if (frame_start) begin
      state_d = COLLECT;
      cnt_d   = '0;
      lag_d   = LW'(ph_clamp) + LW'(VOTE_SPAN);
      sub_d   = '0;
      bits_d  = '0;
      abort_d = (state_q == COLLECT);
    end

    if (sample_en && state_d == COLLECT) begin
      cnt_d = cnt_d + CW'(1);
      if (lag_d != '0) begin
        lag_d = lag_d - LW'(1);
      end else begin
        take  = (sub_d == '0) && (bits_d < BW'(WORD_BITS));
        if (take) bits_d = bits_d + BW'(1);
        sub_d = (sub_d == SW'(OSR - 1)) ? '0 : sub_d + SW'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef MISO_MAJORITY_VOTE_EN
        bit_val   = (hist_q[c][1] & hist_q[c][0]) | (hist_q[c][1] & miso_in[c]) |
                    (hist_q[c][0] & miso_in[c]);
        hist_d[c] = {hist_q[c][0], miso_in[c]};
`else
        bit_val   = miso_in[c];
`endif
        if (take) sh_d[c] = {sh_d[c][WORD_BITS-2:0], bit_val};
      end
      if (cnt_d == CW'(N_LEN)) begin
        state_d = IDLE;
        valid_d = 1'b1;
        for (int c = 0; c < NUM_CH; c++) word_d[c*WORD_BITS +: WORD_BITS] = sh_d[c];
      end
    end
  end

  always_ff @(posedge dataclk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lag_q       <= '0;
      sub_q       <= '0;
      bits_q      <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      frame_abort <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sh_q[c] <= '0;
`ifdef MISO_MAJORITY_VOTE_EN
        hist_q[c] <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lag_q       <= lag_d;
      sub_q       <= sub_d;
      bits_q      <= bits_d;
      word_out    <= word_d;
      word_valid  <= valid_d;
      frame_abort <= abort_d;
      for (int c = 0; c < NUM_CH; c++) begin
        sh_q[c] <= sh_d[c];
`ifdef MISO_MAJORITY_VOTE_EN
        hist_q[c] <= hist_d[c];
`endif
      end
    end
  end

endmodule

// File: doc/miso_oversample_deserializer.md
Name: miso_oversample_deserializer

Overview:
- Parametrised, sequential successor to the combinational MISO downsampler.
- Captures an oversampled MISO bitstream from NUM_CH lines directly, one sample per enabled dataclk cycle, framed by a frame_start pulse.
- Compensates headstage cable delay with a per-frame latched phase lag.
- Emits one registered WORD_BITS-bit word per channel with a valid strobe. Sits between the SPI master's MISO input registers and the data FIFO packer.

Parameters:
- OSR, 4, samples per MISO bit (oversampling ratio, >=2)
- WORD_BITS, 32, output bits per channel per frame
- DELAY_MAX, 9, largest phase lag in samples
- NUM_CH, 2, independent MISO lines sharing framing and phase
- PW, 4, phase_select width (must satisfy 2^PW > DELAY_MAX)

Ports:
- dataclk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- sample_en  in  1  take one sample of every miso_in line this cycle
- miso_in  in  NUM_CH  raw MISO lines, already synchronised to dataclk
- frame_start  in  1  pulse: begin a new frame; this cycle's sample, if taken, is sample 0
- phase_select  in  PW  phase lag in samples; latched on frame_start
- word_out  out  NUM_CH*WORD_BITS  channel c occupies bits [c*WORD_BITS +: WORD_BITS]
- word_valid  out  1  one-cycle pulse when word_out is updated
- frame_abort  out  1  one-cycle pulse when an incomplete frame is discarded
- busy  out  1  high while in COLLECT

Behaviour:
- Reset, with reset_n low at a dataclk edge:
  - word_out=0, word_valid=0, frame_abort=0, busy=0.
  - Sample counter=0, latched phase=0, state IDLE.
- Frame length: N = WORD_BITS*OSR + DELAY_MAX samples (N_MV = N+2 with MISO_MAJORITY_VOTE_EN).
- State IDLE:
  - Samples are ignored.
  - On frame_start: latch ph = min(phase_select, DELAY_MAX), clear counter, go to COLLECT.
  - If sample_en is also high in that cycle, it is sample 0 and the counter becomes 1.
- State COLLECT:
  - Each cycle with sample_en high appends miso_in to the per-channel sample store and increments the counter.
  - Cycles with sample_en low do not advance the frame.
- Completion:
  - The cycle in which the N-th sample is taken: at the next edge, word_out is loaded, word_valid=1 for exactly one cycle, busy=0, state returns to IDLE.
  - Latency from the last sample to word_valid is 1 cycle.
- Bit mapping, per channel, k=0..WORD_BITS-1:
  - Output bit (WORD_BITS-1-k) = sample[ph + k*OSR], so the MSB is the earliest bit.
  - No per-index exceptions.
- phase_select values above DELAY_MAX clamp to DELAY_MAX.
- Changes to phase_select during COLLECT have no effect until the next frame_start.
- frame_start during COLLECT, including the cycle that would have taken the N-th sample:
  - The new frame takes priority.
  - The old frame is discarded, frame_abort pulses one cycle later, and no word_valid is generated for it.
  - ph is re-latched and the counter restarts as in IDLE.
- Samples arriving after completion, before the next frame_start, are ignored.
- word_out holds its last value until the next completion.
- reset_n low mid-frame: immediate return to the reset state; no word_valid and no frame_abort.
- The counter is sized to ceil(log2(N_MV+1)) bits and never wraps.

Optional Feature:
- Macro: MISO_MAJORITY_VOTE_EN.
- Defined:
  - Each output bit is the 2-of-3 majority of samples d, d+1, d+2, where d = ph + k*OSR.
  - Frame length is N+2.
  - word_valid follows the (N+2)-th sample.
- Undefined:
  - Single-sample selection as above, frame length N.
  - No voting logic is instantiated.

Test Plan:
1. Hold reset_n=0 for 3 cycles with random inputs -> word_out=0, word_valid=0, frame_abort=0, busy=0. Release reset -> still idle, with no word_valid until a frame_start occurs.
2. OSR=4, WORD_BITS=32, DELAY_MAX=9, phase_select=0, ch0 bits of 0xA5A50F0F with each bit held for 4 samples, ch1 = ~ch0, 137 consecutive samples -> word_out = {0x5A5AF0F0, 0xA5A50F0F}, word_valid one cycle after sample 136.
3. Same stream prefixed with 9 filler samples, phase_select=9 -> 0xA5A50F0F on ch0. Repeat with phase_select=12 -> identical result (clamped to 9).
4. sample_en toggling every other cycle, phase 3 -> correct word, word_valid after the 137th enabled sample. Change phase_select to 6 at sample 50 -> result still decoded with phase 3.
5. frame_start reasserted at sample 60 -> frame_abort pulse, no word_valid. Then a full 137-sample frame -> correct word, exactly one word_valid.
6. With MISO_MAJORITY_VOTE_EN and a single-sample glitch inserted in every bit of 0x12345678 -> word_out ch0 = 0x12345678, word_valid after the 139th sample.
